card_frame_tx: RTL and testbench

Parametrised UART frame encoder for the blackjack card link, and the successor to the fixed-format card encoder. It takes one game message (type, player index, up to MAX_CARDS 4-bit card codes) and serialises it into a framed byte stream. The stream is a sync byte, a header, packed card nibbles and an XOR checksum. Bytes go into the UART TX FIFO write port, with full-flag backpressure. It sits between the blackjack FSM and the uart block and supports multi-player tables and variable hand sizes.

---
 rtl/blackjack_link_pkg.sv | 48 ++++
 rtl/card_frame_tx.sv | 162 ++++++++++++++++
 tb/tb_card_frame_tx.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/blackjack_link_pkg.sv
// ---------------------------------------------------------------------------
// blackjack_link_pkg
// Shared definitions for the blackjack card link: default frame sync byte,
// message type encoding, frame transmitter FSM states and the header field
// layout. The frame decoder reuses this package, so the header layout lives
// here rather than in the encoder.
// ---------------------------------------------------------------------------
package blackjack_link_pkg;

  // Frame start marker used when the encoder is not given another one.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Game message types carried in the header.
  typedef enum logic [1:0] {
    MSG_DEAL   = 2'd0,
    MSG_HIT    = 2'd1,
    MSG_STAND  = 2'd2,
    MSG_RESULT = 2'd3
  } msg_t;

  // Frame transmitter states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_HDR   = 3'd2,
    ST_CARDS = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5
  } tx_state_e;

  // Header byte layout: [7:6] message type, [5:3] player, [2:0] card count.
  localparam int HDR_TYPE_LSB = 6;
  localparam int HDR_PID_LSB  = 3;
  localparam int HDR_CNT_LSB  = 0;

  // Assemble a header byte from its fields.
  function automatic logic [7:0] pack_header(input msg_t       mtype,
                                             input logic [2:0] pid,
                                             input logic [2:0] cnt);
    logic [7:0] h;
    h = 8'h00;
    h[HDR_TYPE_LSB +: 2] = mtype;
    h[HDR_PID_LSB  +: 3] = pid;
    h[HDR_CNT_LSB  +: 3] = cnt;
    return h;
  endfunction

endpackage

// File: rtl/card_frame_tx.sv
// ---------------------------------------------------------------------------
// card_frame_tx
// Serialises one blackjack game message into a framed byte stream for the
// UART TX FIFO: SYNC_BYTE, header, packed card nibbles (two cards per byte,
// low nibble first) and an XOR checksum over header and card bytes.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   send        request pulse, accepted only while busy=0
//   msg_type    message type
//   player_id   player index (zero-extended to 3 bits in the header)
//   card_count  number of valid cards (clamped to MAX_CARDS)
//   cards       card i in bits [4i+3:4i]
//   tx_full     UART TX FIFO full; stalls the frame while high
//   wr_uart     FIFO write strobe
//   w_data      FIFO write data
//   busy        frame in progress
//   done        one-cycle pulse after the last byte is written
//   overrun     one-cycle pulse when send arrives while busy
// ---------------------------------------------------------------------------
module card_frame_tx
  import blackjack_link_pkg::*;
#(
  parameter int unsigned MAX_CARDS = 6,
  parameter int unsigned PLAYER_W  = 2,
  parameter logic [7:0]  SYNC_BYTE = blackjack_link_pkg::SYNC_BYTE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   send,
  input  msg_t                   msg_type,
  input  logic [PLAYER_W-1:0]    player_id,
  input  logic [2:0]             card_count,
  input  logic [4*MAX_CARDS-1:0] cards,
  input  logic                   tx_full,
  output logic                   wr_uart,
  output logic [7:0]             w_data,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_CARDS);

  tx_state_e              state_q;
  msg_t                   msg_q;
  logic [PLAYER_W-1:0]    pid_q;
  logic [2:0]             count_q;
  logic [4*MAX_CARDS-1:0] cards_q;
  logic [1:0]             idx_q;
  logic [7:0]             csum_q;
  logic                   overrun_q;

  logic [2:0]  count_clamp_d;
  logic [7:0]  csum_d;
  logic [7:0]  hdr_s;
  logic [7:0]  card_byte_s;
  logic [31:0] cards_ext_s;
  logic [3:0]  nib_s [8];
  logic [3:0]  nbytes_s;
  logic        last_card_s;
  logic        sending_s;

  assign count_clamp_d = (card_count > MAX_CNT) ? MAX_CNT : card_count;
  assign hdr_s         = pack_header(msg_q, 3'(pid_q), count_q);
  assign nbytes_s      = ({1'b0, count_q} + 4'd1) >> 1;
  assign last_card_s   = (({2'b00, idx_q} + 4'd1) == nbytes_s);
  assign csum_d        = csum_q ^ w_data;

  assign sending_s = (state_q == ST_SYNC) || (state_q == ST_HDR) ||
                     (state_q == ST_CARDS) || (state_q == ST_CSUM);
  assign wr_uart   = sending_s && !tx_full;
  assign busy      = sending_s;
  assign done      = (state_q == ST_DONE);
  assign overrun   = overrun_q;

  // Nibble table of the latched hand: cards at or beyond the count read as
  // zero, which also supplies the pad nibble of an odd-sized hand.
  always_comb begin
    cards_ext_s = 32'(cards_q);
    for (int i = 0; i < 8; i++) begin
      nib_s[i] = (i < int'(count_q)) ? cards_ext_s[4*i +: 4] : 4'h0;
    end
    card_byte_s = {nib_s[{idx_q, 1'b1}], nib_s[{idx_q, 1'b0}]};
  end

  // Byte presented to the FIFO, selected by the current state.
  always_comb begin
    case (state_q)
      ST_IDLE:  w_data = 8'h00;
      ST_SYNC:  w_data = SYNC_BYTE;
      ST_HDR:   w_data = hdr_s;
      ST_CARDS: w_data = card_byte_s;
      ST_CSUM:  w_data = csum_q;
      ST_DONE:  w_data = 8'h00;
      default:  w_data = 8'h00;
    endcase
  end

  // Frame FSM: request latch, byte sequencing and checksum accumulation.
  // Progress is made only on cycles where a byte is actually written.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      msg_q     <= MSG_DEAL;
      pid_q     <= {PLAYER_W{1'b0}};
      count_q   <= 3'd0;
      cards_q   <= {(4*MAX_CARDS){1'b0}};
      idx_q     <= 2'd0;
      csum_q    <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= send && sending_s;
      case (state_q)
        // DONE already has busy low, so a new request is taken there too.
        ST_IDLE, ST_DONE: begin
          if (send) begin
            msg_q   <= msg_type;
            pid_q   <= player_id;
            count_q <= count_clamp_d;
            cards_q <= cards;
            idx_q   <= 2'd0;
            csum_q  <= 8'h00;
            state_q <= ST_SYNC;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SYNC: begin
          if (wr_uart) begin
            state_q <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (wr_uart) begin
            csum_q  <= csum_d;
            idx_q   <= 2'd0;
            state_q <= (count_q != 3'd0) ? ST_CARDS : ST_CSUM;
          end
        end
        ST_CARDS: begin
          if (wr_uart) begin
            csum_q <= csum_d;
            if (last_card_s) begin
              state_q <= ST_CSUM;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        ST_CSUM: begin
          if (wr_uart) begin
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_card_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_card_frame_tx
// Self-checking bench for card_frame_tx. Expected frames are built from the
// message fields with plain arithmetic into a queue; the bench then steps
// the DUT cycle by cycle, deciding tx_full itself, and checks every output.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_card_frame_tx;
  import blackjack_link_pkg::*;

  localparam int MAXC = 6;
  localparam int PW   = 2;
  localparam int CW   = 4 * MAXC;

  logic          clk;
  logic          rst;
  logic          send;
  msg_t          msg_type;
  logic [PW-1:0] player_id;
  logic [2:0]    card_count;
  logic [CW-1:0] cards;
  logic          tx_full;
  logic          wr_uart;
  logic [7:0]    w_data;
  logic          busy;
  logic          done;
  logic          overrun;

  int         n_checks;
  int         n_pass;
  bit         ov_exp;
  logic [7:0] exp_q[$];

  card_frame_tx #(
    .MAX_CARDS(MAXC),
    .PLAYER_W (PW),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .send      (send),
    .msg_type  (msg_type),
    .player_id (player_id),
    .card_count(card_count),
    .cards     (cards),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .w_data    (w_data),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference frame: sync, header, ceil(c/2) card bytes, XOR checksum.
  task automatic build_frame(input int mt, input int pid, input int cnt, input logic [CW-1:0] cd);
    int c, hdr, cs, lo, hi, b;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    c   = (cnt > MAXC) ? MAXC : cnt;
    hdr = mt * 64 + pid * 8 + c;
    exp_q.push_back(hdr[7:0]);
    cs = hdr;
    for (int k = 0; k < (c + 1) / 2; k++) begin
      lo = int'(cd[8*k +: 4]);
      hi = (2*k + 1 < c) ? int'(cd[8*k + 4 +: 4]) : 0;
      b  = hi * 16 + lo;
      cs = cs ^ b;
      exp_q.push_back(b[7:0]);
    end
    exp_q.push_back(cs[7:0]);
  endtask

  task automatic drive_random_fields();
    logic [31:0] r;
    r = $urandom;
    msg_type   = msg_t'(r[1:0]);
    r = $urandom;
    player_id  = r[PW-1:0];
    card_count = r[10:8];
    r = $urandom;
    cards      = r[CW-1:0];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      send    = 1'b0;
      tx_full = 1'($urandom_range(0, 1));
      drive_random_fields();
      @(negedge clk);
      check_eq("idle_wr_uart", wr_uart, 1'b0);
      check_eq("idle_busy", busy, 1'b0);
      check_eq("idle_done", done, 1'b0);
      check_eq("idle_overrun", overrun, 1'b0);
    end
  endtask

  // Request a frame (called just after a falling edge in an idle or done
  // cycle) and follow it to its done cycle, or abort it with reset once
  // abort_after bytes have been written.
  task automatic run_frame(input int mt, input int pid, input int cnt, input logic [CW-1:0] cd,
                           input int stall_pct, input int stall_at, input int stall_len,
                           input int ov_pct, input int abort_after);
    int n, left;
    bit full;
    build_frame(mt, pid, cnt, cd);
    send       = 1'b1;
    msg_type   = msg_t'(mt[1:0]);
    player_id  = pid[PW-1:0];
    card_count = cnt[2:0];
    cards      = cd;
    n    = 0;
    left = stall_len;
    ov_exp = 1'b0;
    while (n < exp_q.size()) begin
      @(posedge clk); #1;
      send = ($urandom_range(1, 100) <= ov_pct);
      drive_random_fields();
      if (n == stall_at && left > 0) begin
        full = 1'b1;
        left--;
      end else begin
        full = ($urandom_range(1, 100) <= stall_pct);
      end
      tx_full = full;
      @(negedge clk);
      check_eq("busy", busy, 1'b1);
      check_eq("done_early", done, 1'b0);
      check_eq("overrun", overrun, ov_exp);
      check_eq("wr_uart", wr_uart, !full);
      check_eq($sformatf("byte%0d", n), w_data, exp_q[n]);
      ov_exp = send;
      if (!full) n++;
      if (abort_after >= 0 && n == abort_after) begin
        @(posedge clk); #1;
        rst     = 1'b1;
        send    = 1'b0;
        tx_full = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ov_exp = 1'b0;
        @(negedge clk);
        check_eq("abort_wr_uart", wr_uart, 1'b0);
        check_eq("abort_w_data", w_data, 8'h00);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_overrun", overrun, 1'b0);
        return;
      end
    end
    @(posedge clk); #1;
    send    = 1'b0;
    tx_full = 1'($urandom_range(0, 1));
    drive_random_fields();
    @(negedge clk);
    check_eq("done", done, 1'b1);
    check_eq("done_busy", busy, 1'b0);
    check_eq("done_wr_uart", wr_uart, 1'b0);
    check_eq("done_overrun", overrun, ov_exp);
  endtask

  initial begin
    logic [31:0] r;
    n_checks = 0;
    n_pass   = 0;
    ov_exp   = 1'b0;
    rst      = 1'b1;
    send     = 1'b1;
    tx_full  = 1'b0;
    drive_random_fields();

    // Reset held with send asserted: reset must win.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_wr_uart", wr_uart, 1'b0);
    check_eq("rst_w_data", w_data, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_overrun", overrun, 1'b0);
    @(posedge clk); #1;
    rst  = 1'b0;
    send = 1'b0;
    @(negedge clk);
    check_eq("rst_send_ignored", busy, 1'b0);
    idle(2);

    // DEAL, player 1, cards {A,3}; unused card slots hold junk.
    run_frame(0, 1, 2, 24'h7C5E3A, 0, -1, 0, 0, -1);
    // HIT, player 0, cards {1,2,3}, requested in the done cycle.
    run_frame(1, 0, 3, 24'h9A8321, 0, -1, 0, 0, -1);
    idle(2);
    // STAND, player 2, no cards.
    run_frame(2, 2, 0, 24'hFFFFFF, 0, -1, 0, 0, -1);
    idle(1);
    // Five-cycle stall on the second card byte.
    run_frame(0, 3, 4, 24'h00B7C2, 0, 3, 5, 0, -1);
    idle(1);
    // Requests while busy, and a count above MAX_CARDS.
    run_frame(3, 1, 7, 24'h654321, 0, -1, 0, 40, -1);
    idle(1);
    // Reset right after the header write, then a fresh frame.
    run_frame(1, 2, 5, 24'h0ED9C8, 0, -1, 0, 0, 2);
    idle(3);
    run_frame(1, 2, 5, 24'h0ED9C8, 0, -1, 0, 0, -1);

    // Randomised frames with random stalls, overruns and gaps.
    for (int f = 0; f < 40; f++) begin
      r = $urandom;
      run_frame(int'(r[1:0]), int'(r[3:2]) % (1 << PW), int'(r[6:4]), r[31:8],
                20, -1, 0, 10, -1);
      idle($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
